// File: rtl/rpe_pkg.sv
// Shared types and sizes for the RPE systolic array scheduler.
package rpe_pkg;

    localparam int RPE_SIZE = 8;
    localparam int RPE_W_W  = 5;
    localparam int RPE_A_W  = 7;

    // Partial sums grow by log2(SIZE) bits over a 16-bit product.
    function automatic int RPE_PSW(input int size);
        return 16 + $clog2(size);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rpe_skew_line.sv
// Triangular delay line: lane i is delayed i cycles (REV=0) or SIZE-1-i cycles (REV=1).
module rpe_skew_line
    import rpe_pkg::*;
#(
    parameter int DW   = RPE_A_W,
    parameter int SIZE = RPE_SIZE,
    parameter bit REV  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SIZE*DW-1:0] data_i,
    output logic [SIZE*DW-1:0] data_o
);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        localparam int D = REV ? (SIZE - 1 - i) : i;

        if (D == 0) begin : g_pass
            assign data_o[i*DW +: DW] = data_i[i*DW +: DW];
        end else begin : g_dly
            logic [DW-1:0] stage_q [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= data_i[i*DW +: DW];
                    for (int k = 1; k < D; k++) stage_q[k] <= stage_q[k-1];
                end
            end

            assign data_o[i*DW +: DW] = stage_q[D-1];
        end
    end

endmodule

// File: rtl/rpe_array_sched.sv
// Job sequencer for the SIZE x SIZE RPE array: weight load, skewed activation stream, output deskew.
// Optional build macro RPE_SCHED_PERF_EN adds perf_busy_o / perf_bubble_o cycle counters.
module rpe_array_sched
    import rpe_pkg::*;
#(
    parameter int SIZE   = RPE_SIZE,
    parameter int PSW    = RPE_PSW(SIZE),
    parameter int NVEC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [NVEC_W-1:0]     cfg_nvec_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  w_valid_i,
    input  logic [SIZE*RPE_W_W-1:0] w_data_i,
    output logic                  w_ready_o,
    input  logic                  a_valid_i,
    input  logic [SIZE*RPE_A_W-1:0] a_data_i,
    output logic                  a_ready_o,
    output logic                  arr_w_valid_o,
    output logic [SIZE*RPE_W_W-1:0] arr_w_data_o,
    output logic [SIZE*RPE_A_W-1:0] arr_act_o,
    input  logic [SIZE*PSW-1:0]   arr_psum_i,
    output logic                  res_valid_o,
    output logic [SIZE*PSW-1:0]   res_data_o
`ifdef RPE_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_busy_o,
    output logic [31:0]           perf_bubble_o
`endif
);

    localparam int LAT = 2 * SIZE;

    sched_state_t          state_q, state_d;
    logic [NVEC_W-1:0]     nvec_q, nvec_d;
    logic [NVEC_W-1:0]     cnt_q, cnt_d;
    logic [LAT-1:0]        vld_q;
    logic [SIZE*RPE_A_W-1:0] act_q;
    logic [SIZE*PSW-1:0]   res_q;
    logic [SIZE*PSW-1:0]   psum_aligned;
    logic                  w_ready, a_ready, w_hs, a_hs, done;

    always_comb begin
        state_d = state_q;
        nvec_d  = nvec_q;
        cnt_d   = cnt_q;
        w_ready = 1'b0;
        a_ready = 1'b0;
        w_hs    = 1'b0;
        a_hs    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nvec_d  = cfg_nvec_i;
                    cnt_d   = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                w_hs    = w_valid_i;
                if (w_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == NVEC_W'(SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = (nvec_q == '0) ? DONE : STREAM;
                    end
                end
            end
            STREAM: begin
                a_ready = 1'b1;
                a_hs    = a_valid_i;
                if (a_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == nvec_q) state_d = DRAIN;
                end
            end
            // Leave once only the output stage may still hold a token.
            DRAIN: begin
                if (vld_q[LAT-2:0] == '0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nvec_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            act_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            nvec_q  <= nvec_d;
            cnt_q   <= cnt_d;
            vld_q   <= {vld_q[LAT-2:0], a_hs};
            act_q   <= a_hs ? a_data_i : '0;
            if (vld_q[LAT-2]) res_q <= psum_aligned;
        end
    end

    rpe_skew_line #(.DW(RPE_A_W), .SIZE(SIZE), .REV(1'b0)) u_in_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (act_q),
        .data_o (arr_act_o)
    );

    rpe_skew_line #(.DW(PSW), .SIZE(SIZE), .REV(1'b1)) u_out_deskew (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (arr_psum_i),
        .data_o (psum_aligned)
    );

    // busy covers the start cycle itself, so it is gated to stay low while in reset.
    assign busy_o        = rst_n & ((state_q != IDLE) | start_i);
    assign done_o        = done;
    assign w_ready_o     = w_ready;
    assign a_ready_o     = a_ready;
    assign arr_w_valid_o = w_hs;
    assign arr_w_data_o  = w_ready ? w_data_i : '0;
    assign res_valid_o   = vld_q[LAT-1];
    assign res_data_o    = res_q;

`ifdef RPE_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q   <= '0;
            perf_bubble_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            perf_busy_q   <= 32'd1;
            perf_bubble_q <= '0;
        end else begin
            if (state_q != IDLE && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
            if (state_q == STREAM && !a_hs && perf_bubble_q != '1)
                perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign perf_busy_o   = perf_busy_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_rpe_array_sched.sv
// Self-checking bench for rpe_array_sched with a behavioural array model and a job-level scoreboard.
module tb_rpe_array_sched;
    import rpe_pkg::*;

    localparam int S   = 8;
    localparam int PSW = 19;
    localparam int NW  = 16;
    localparam int LAT = 2 * S;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [NW-1:0]     cfg_nvec_i = '0;
    logic              busy_o, done_o;
    logic              w_valid_i = 1'b0;
    logic [S*5-1:0]    w_data_i = '0;
    logic              w_ready_o;
    logic              a_valid_i = 1'b0;
    logic [S*7-1:0]    a_data_i = '0;
    logic              a_ready_o;
    logic              arr_w_valid_o;
    logic [S*5-1:0]    arr_w_data_o;
    logic [S*7-1:0]    arr_act_o;
    logic [S*PSW-1:0]  arr_psum_i = '0;
    logic              res_valid_o;
    logic [S*PSW-1:0]  res_data_o;

    rpe_array_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .cfg_nvec_i    (cfg_nvec_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .w_valid_i     (w_valid_i),
        .w_data_i      (w_data_i),
        .w_ready_o     (w_ready_o),
        .a_valid_i     (a_valid_i),
        .a_data_i      (a_data_i),
        .a_ready_o     (a_ready_o),
        .arr_w_valid_o (arr_w_valid_o),
        .arr_w_data_o  (arr_w_data_o),
        .arr_act_o     (arr_act_o),
        .arr_psum_i    (arr_psum_i),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edgeCount = 0;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name, input int cycles);
        total++;
        bad++;
        $display("[TB] FAIL %s: no completion within %0d cycles", name, cycles);
    endtask

    // The array encodes both operands as odd values 2x+1 (two's complement x).
    function automatic int wv(input logic [4:0] w);
        return 2 * int'($signed(w)) + 1;
    endfunction

    function automatic int av(input logic [6:0] a);
        return 2 * int'($signed(a)) + 1;
    endfunction

    // Environment: weight-stationary array whose bottom of column j shows the diagonal that entered row 0 S-1+j cycles earlier.
    logic [S*5-1:0] arrW [S] = '{default: '0};
    logic [S*7-1:0] actHist [int];
    int             envSum;
    int             envIdx;
    logic [31:0]    envTmp;
    logic [S*7-1:0] envRow;
    logic [S*PSW-1:0] envPs;

    always @(negedge clk) begin : arrayModel
        actHist[edgeCount] = arr_act_o;
        for (int j = 0; j < S; j++) begin
            envSum = 0;
            for (int r = 0; r < S; r++) begin
                envIdx = edgeCount - (S - 1) + r - j;
                envRow = actHist.exists(envIdx) ? actHist[envIdx] : '0;
                envSum += wv(arrW[r][5*j +: 5]) * av(envRow[7*r +: 7]);
            end
            envTmp = envSum;
            envPs[PSW*j +: PSW] = envTmp[PSW-1:0];
        end
        arr_psum_i = envPs;
        if (arr_w_valid_o) begin
            for (int r = S - 1; r > 0; r--) arrW[r] = arrW[r-1];
            arrW[0] = arr_w_data_o;
        end
    end

    // Scoreboard state: job phase, accepted weight rows, expected results and skewed activations by cycle.
    bit               active = 1'b0;
    bit               prevActive;
    int               wCnt, vCnt, nvecM;
    int               doneAt = -1;
    logic [S*5-1:0]   wRows [$];
    logic [S*PSW-1:0] resMap [int];
    logic [S*7-1:0]   actMap [int];
    logic [S*PSW-1:0] lastRes = '0;
    logic [S*PSW-1:0] resLog [$];
    logic [S*PSW-1:0] sbRes;
    logic [S*7-1:0]   sbAct;
    logic [S*5-1:0]   sbW;
    logic [31:0]      sbTmp;
    int               sbSum;
    bit               expW, expA, expV;
    int               m;

    always @(negedge clk) begin : compare
        m = edgeCount;
        if (!rst_n) begin
            checkOutput("resetCtl", {busy_o, done_o, w_ready_o, a_ready_o, arr_w_valid_o, res_valid_o}, '0);
            checkOutput("resetWData", arr_w_data_o, '0);
            checkOutput("resetAct", arr_act_o, '0);
            checkOutput("resetRes", res_data_o, '0);
            active = 1'b0;
            doneAt = -1;
            wRows.delete();
            resMap.delete();
            actMap.delete();
            lastRes = '0;
        end else begin
            expW = active && (wCnt < S);
            expA = active && (wCnt == S) && (vCnt < nvecM);
            checkOutput("wReady", w_ready_o, expW);
            checkOutput("aReady", a_ready_o, expA);
            checkOutput("arrWValid", arr_w_valid_o, expW && w_valid_i);
            checkOutput("arrWData", arr_w_data_o, expW ? w_data_i : '0);
            checkOutput("busy", busy_o, active || start_i);
            checkOutput("done", done_o, active && (doneAt == m));
            sbAct = actMap.exists(m) ? actMap[m] : '0;
            actMap.delete(m);
            checkOutput("arrAct", arr_act_o, sbAct);
            expV = resMap.exists(m);
            if (expV) begin
                lastRes = resMap[m];
                resMap.delete(m);
                resLog.push_back(res_data_o);
            end
            checkOutput("resValid", res_valid_o, expV);
            checkOutput("resData", res_data_o, lastRes);

            prevActive = active;
            if (expW && w_valid_i) begin
                wRows.push_back(w_data_i);
                wCnt++;
                if (wCnt == S && nvecM == 0) doneAt = m + 1;
            end
            if (expA && a_valid_i) begin
                for (int j = 0; j < S; j++) begin
                    sbSum = 0;
                    for (int r = 0; r < S; r++) begin
                        sbW = wRows[S-1-r];
                        sbSum += wv(sbW[5*j +: 5]) * av(a_data_i[7*r +: 7]);
                    end
                    sbTmp = sbSum;
                    sbRes[PSW*j +: PSW] = sbTmp[PSW-1:0];
                end
                resMap[m + LAT] = sbRes;
                for (int r = 0; r < S; r++) begin
                    sbAct = actMap.exists(m + 1 + r) ? actMap[m + 1 + r] : '0;
                    sbAct[7*r +: 7] = a_data_i[7*r +: 7];
                    actMap[m + 1 + r] = sbAct;
                end
                vCnt++;
                if (vCnt == nvecM) doneAt = m + LAT + 1;
            end
            if (prevActive && doneAt == m) begin
                active = 1'b0;
                doneAt = -1;
            end
            if (!prevActive && start_i) begin
                active = 1'b1;
                nvecM  = int'(cfg_nvec_i);
                wCnt   = 0;
                vCnt   = 0;
                doneAt = -1;
                wRows.delete();
            end
        end
    end

    logic [S*5-1:0] wMem [S];
    logic [S*7-1:0] actMem [16];
    logic [63:0]    rnd;

    task automatic randomFill();
        for (int k = 0; k < S; k++) begin
            rnd = {$urandom(), $urandom()};
            wMem[k] = rnd[S*5-1:0];
        end
        for (int k = 0; k < 16; k++) begin
            rnd = {$urandom(), $urandom()};
            actMem[k] = rnd[S*7-1:0];
        end
    endtask

    task automatic startJob(input int nvec);
        cfg_nvec_i = NW'(nvec);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cfg_nvec_i = NW'($urandom());
    endtask

    task automatic driveLoad(input bit toggle, input bit startNoise);
        int idx = 0;
        int guard = 0;
        bit hs;
        while (idx < S && guard < 200) begin
            w_valid_i = toggle ? 1'($urandom_range(1)) : 1'b1;
            rnd = {$urandom(), $urandom()};
            w_data_i = w_valid_i ? wMem[idx] : rnd[S*5-1:0];
            start_i = startNoise ? 1'($urandom_range(1)) : 1'b0;
            cfg_nvec_i = NW'($urandom_range(9));
            @(negedge clk);
            hs = w_valid_i && w_ready_o;
            @(posedge clk); #1;
            if (hs) idx++;
            guard++;
        end
        w_valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < S) reportTimeout("weightLoad", guard);
    endtask

    task automatic driveStream(input int nvec, input int bubblePct, input int gapAfter,
                               input int gapLen, input bit startNoise);
        int idx = 0;
        int guard = 0;
        int gap = 0;
        bit hs;
        while (idx < nvec && guard < 2000) begin
            if (gap > 0) begin
                a_valid_i = 1'b0;
                gap--;
            end else begin
                a_valid_i = ($urandom_range(99) >= bubblePct);
            end
            rnd = {$urandom(), $urandom()};
            a_data_i = a_valid_i ? actMem[idx] : rnd[S*7-1:0];
            start_i = startNoise ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            hs = a_valid_i && a_ready_o;
            @(posedge clk); #1;
            if (hs) begin
                if (idx == gapAfter) gap = gapLen;
                idx++;
            end
            guard++;
        end
        a_valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < nvec) reportTimeout("actStream", guard);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            seen = done_o;
            n++;
        end
        @(posedge clk); #1;
        if (!seen) reportTimeout("waitDone", budget);
    endtask

    // One whole job: start, weight load, activation stream, wait for done.
    task automatic applyStimulus(input int nvec, input bit toggleW, input int bubblePct,
                                 input int gapAfter, input int gapLen, input bit startNoise);
        resLog.delete();
        startJob(nvec);
        driveLoad(toggleW, startNoise);
        if (nvec > 0) driveStream(nvec, bubblePct, gapAfter, gapLen, startNoise);
        waitDone(LAT + 100);
    endtask

    function automatic logic [S*PSW-1:0] splat(input logic [PSW-1:0] v);
        logic [S*PSW-1:0] r;
        for (int j = 0; j < S; j++) r[PSW*j +: PSW] = v;
        return r;
    endfunction

    function automatic logic [S*PSW-1:0] firstRes();
        return (resLog.size() > 0) ? resLog[0] : '0;
    endfunction

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Unit weights and activations: every column sums to +8.
        for (int k = 0; k < S; k++) wMem[k] = '0;
        actMem[0] = '0;
        applyStimulus(1, 1'b0, 0, -1, 0, 1'b0);
        checkOutput("t1Count", resLog.size(), 1);
        checkOutput("t1Value", firstRes(), splat(19'd8));

        actMem[0] = '1;
        applyStimulus(1, 1'b0, 0, -1, 0, 1'b0);
        checkOutput("t2Count", resLog.size(), 1);
        checkOutput("t2Value", firstRes(), splat(19'h7FFF8));

        // Ten random vectors with a two-cycle gap after the fourth.
        randomFill();
        applyStimulus(10, 1'b0, 0, 3, 2, 1'b1);
        checkOutput("t3Count", resLog.size(), 10);

        // Zero-vector job: weights only, then done, with start noise while busy.
        applyStimulus(0, 1'b0, 0, -1, 0, 1'b1);
        checkOutput("t4Count", resLog.size(), 0);

        // Reset in the middle of streaming drops the job.
        randomFill();
        resLog.delete();
        startJob(10);
        driveLoad(1'b0, 1'b0);
        driveStream(3, 0, -1, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5Dropped", resLog.size(), 0);
        applyStimulus(6, 1'b0, 25, -1, 0, 1'b0);
        checkOutput("t5Count", resLog.size(), 6);

        // Row-order readback: row k holds weight k, activation row r is r -> 344 per column.
        for (int k = 0; k < S; k++)
            for (int j = 0; j < S; j++) wMem[k][5*j +: 5] = 5'(k);
        for (int r = 0; r < S; r++) actMem[0][7*r +: 7] = 7'(r);
        applyStimulus(1, 1'b1, 0, -1, 0, 1'b0);
        checkOutput("t6Count", resLog.size(), 1);
        checkOutput("t6Order", firstRes(), splat(19'd344));

        // Random jobs with toggling weight valid and bubbly streams.
        for (int n = 0; n < 3; n++) begin
            randomFill();
            applyStimulus(5 + n * 3, 1'b1, 30, -1, 0, 1'b1);
            checkOutput("randCount", resLog.size(), 5 + n * 3);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
